// File: rtl/mem_access_unit_if.sv
`timescale 1ns/1ps
// mem_access_unit_if
//   Data-memory req/ack port of the memory-stage access controller.
//   master : the access unit (drives request, address, data, byte enables)
//   slave  : the data memory (drives ack and read data)
//   Signals:
//     mem_req_o    request valid (held until ack)
//     mem_we_o     request is a write
//     mem_addr_o   word-aligned byte address
//     mem_wdata_o  lane-replicated store data
//     mem_be_o     byte enables
//     mem_ack_i    request done; read data valid this cycle
//     mem_rdata_i  read word
interface mem_access_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
//   Memory-stage access controller between EX/MEM and MEM/WB. Runs one load
//   or store per instruction over a req/ack port, extends load data, and
//   stalls the pipeline while the access is outstanding.
//   Ports:
//     clk_i, rst_i (async, active-low)
//     start_i                      pipeline running; gates new accesses
//     RegWrite_i, MemReg_i,
//     MemRead_i, MemWrite_i        EX/MEM control
//     funct3_i                     access size/sign
//     rd_addr_i, alu_result_i      destination register, address/ALU result
//     wdata_i                      store data
//     mem                          data-memory port (master side)
//     RegWrite_o, MemReg_o,
//     rd_addr_o, data1_o, data2_o  to MEM/WB (data2_o = extended load data)
//     stall_o                      freeze upstream stages and hold MEM/WB
//     err_o                        pulse on misaligned access or timeout
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              RegWrite_i,
    input  logic              MemReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       wdata_i,
    mem_access_unit_if.master mem,
    output logic              RegWrite_o,
    output logic              MemReg_o,
    output logic [4:0]        rd_addr_o,
    output logic [31:0]       data1_o,
    output logic [31:0]       data2_o,
    output logic              stall_o,
    output logic              err_o
);
    // Counter only needs to reach TIMEOUT_CYCLES-1: expiry is detected on
    // the last BUSY cycle rather than after a further increment.
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;

    logic          mem_op, legal, misalign, aligned_op;
    logic [3:0]    be_n;
    logic [31:0]   wdat_n, ext;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    // Decode: legality, alignment and store lane steering.
    always_comb begin
        mem_op = start_i & (MemRead_i | MemWrite_i);
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = MemRead_i;
            default:                legal = 1'b0;
        endcase
        misalign = mem_op & (~legal
                   | ((funct3_i[1:0] == 2'b01) & alu_result_i[0])
                   | ((funct3_i[1:0] == 2'b10) & (|alu_result_i[1:0])));
        aligned_op = mem_op & ~misalign;

        be_n   = 4'b1111;
        wdat_n = '0;
        if (!MemRead_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    wdat_n = {4{wdata_i[7:0]}};
                    be_n   = 4'b0001 << alu_result_i[1:0];
                end
                2'b01: begin
                    wdat_n = {2{wdata_i[15:0]}};
                    be_n   = alu_result_i[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdat_n = wdata_i;
                    be_n   = 4'b1111;
                end
            endcase
        end
    end

    // Load extraction uses the size/offset latched at launch.
    always_comb begin
        case (off_q)
            2'd0:    byte_v = mem.mem_rdata_i[7:0];
            2'd1:    byte_v = mem.mem_rdata_i[15:8];
            2'd2:    byte_v = mem.mem_rdata_i[23:16];
            default: byte_v = mem.mem_rdata_i[31:24];
        endcase
        half_v = off_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  ext = {{24{byte_v[7]}}, byte_v};
            3'b100:  ext = {24'd0, byte_v};
            3'b001:  ext = {{16{half_v[15]}}, half_v};
            3'b101:  ext = {16'd0, half_v};
            3'b010:  ext = mem.mem_rdata_i;
            default: ext = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    addr_d  = {alu_result_i[31:2], 2'b00};
                    wdat_d  = wdat_n;
                    be_d    = be_n;
                    we_d    = ~MemRead_i;
                    f3_d    = funct3_i;
                    off_d   = alu_result_i[1:0];
                end
            end
            BUSY: begin
                // Ack wins over a simultaneous expiry.
                if (mem.mem_ack_i) begin
                    state_d = DONE;
                    data_d  = ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            err_q   <= err_d;
        end
    end

    assign mem.mem_req_o   = (state_q == BUSY);
    assign mem.mem_we_o    = (state_q == BUSY) & we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdat_q;
    assign mem.mem_be_o    = be_q;

    // Combinational terms are gated by rst_i so reset forces them low even
    // while EX/MEM still presents a memory instruction.
    assign stall_o    = (rst_i & (state_q == IDLE) & aligned_op) | (state_q == BUSY);
    assign err_o      = err_q | (rst_i & (state_q == IDLE) & misalign);
    assign RegWrite_o = RegWrite_i & ~(misalign & MemRead_i);
    assign MemReg_o   = MemReg_i;
    assign rd_addr_o  = rd_addr_i;
    assign data1_o    = alu_result_i;
    assign data2_o    = (state_q == DONE) ? data_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// tb_mem_access_unit
//   Directed-vector bench for mem_access_unit with a behavioural model of
//   sizes, lanes, extension and access timing, and a per-cycle compare.
module tb_mem_access_unit;
    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        RegWrite_i = 1'b0, MemReg_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic [31:0] alu_result_i = '0, wdata_i = '0;
    logic        RegWrite_o, MemReg_o, stall_o, err_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] data1_o, data2_o;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .RegWrite_i(RegWrite_i), .MemReg_i(MemReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .funct3_i(funct3_i), .rd_addr_i(rd_addr_i),
        .alu_result_i(alu_result_i), .wdata_i(wdata_i),
        .mem(bus),
        .RegWrite_o(RegWrite_o), .MemReg_o(MemReg_o), .rd_addr_o(rd_addr_o),
        .data1_o(data1_o), .data2_o(data2_o), .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misaligned(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        ok = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        return !ok || ((a % m_size(f3)) != 0);
    endfunction

    task automatic m_lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                           output logic [3:0] be, output logic [31:0] wd);
        int unsigned sz;
        longint unsigned mask, chunk, acc;
        sz    = m_size(f3);
        mask  = (64'd1 << (8 * sz)) - 1;
        chunk = longint'(w) & mask;
        acc   = 0;
        for (int unsigned i = 0; i < 4 / sz; i++) acc = acc | (chunk << (8 * sz * i));
        wd = acc[31:0];
        be = 4'(((1 << sz) - 1) << (a % 4));
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        int unsigned sz;
        longint unsigned mask, v;
        sz   = m_size(f3);
        mask = (64'd1 << (8 * sz)) - 1;
        v    = (longint'(r) >> (8 * (a % 4))) & mask;
        if (f3[2] == 1'b0 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- per-cycle expectations ----------------
    bit          exp_valid = 0, exp_bus = 0;
    logic        exp_stall, exp_req, exp_we, exp_err, exp_rw, exp_mr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_d1, exp_d2, exp_addr, exp_wd;
    logic [3:0]  exp_be;

    always @(negedge clk_i) begin
        if (exp_valid) begin
            chk("stall",    32'(stall_o),       32'(exp_stall));
            chk("mem_req",  32'(bus.mem_req_o), 32'(exp_req));
            chk("mem_we",   32'(bus.mem_we_o),  32'(exp_we));
            chk("err",      32'(err_o),         32'(exp_err));
            chk("regwrite", 32'(RegWrite_o),    32'(exp_rw));
            chk("memreg",   32'(MemReg_o),      32'(exp_mr));
            chk("rd_addr",  32'(rd_addr_o),     32'(exp_rd));
            chk("data1",    data1_o,            exp_d1);
            chk("data2",    data2_o,            exp_d2);
            if (exp_bus) begin
                chk("mem_addr",  bus.mem_addr_o,     exp_addr);
                chk("mem_wdata", bus.mem_wdata_o,    exp_wd);
                chk("mem_be",    32'(bus.mem_be_o),  32'(exp_be));
            end
        end
    end

    // ---------------- observed DUT values for literal pins ----------------
    int          stall_cnt, err_cnt, req_cnt;
    bit          seen_req;
    logic [31:0] q_addr, q_wd, last_d2, last_d1;
    logic [3:0]  q_be, last_be;
    logic        q_we, last_rw;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        #1;
        stall_cnt += int'(stall_o);
        err_cnt   += int'(err_o);
        req_cnt   += int'(bus.mem_req_o);
        if (bus.mem_req_o && !seen_req) begin
            seen_req = 1;
            q_addr = bus.mem_addr_o;
            q_wd   = bus.mem_wdata_o;
            q_be   = bus.mem_be_o;
            q_we   = bus.mem_we_o;
        end
        last_d2 = data2_o;
        last_d1 = data1_o;
        last_be = bus.mem_be_o;
        last_rw = RegWrite_o;
    endtask

    // Runs one instruction from IDLE. ack_at: BUSY cycle carrying the ack
    // (0 = never). Entered and left at posedge+1.
    task automatic run_op(input logic st, input logic rw, input logic mr, input logic mrd,
                          input logic mwr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] rdat,
                          input int ack_at, input logic stray_ack);
        bit memop, ld, mis, timed_out;
        int nb;
        logic [3:0]  be;
        logic [31:0] wdl;
        memop = st && (mrd || mwr);
        ld    = mrd;
        mis   = memop && m_misaligned(ld, f3, alu);
        start_i = st; RegWrite_i = rw; MemReg_i = mr; MemRead_i = mrd; MemWrite_i = mwr;
        funct3_i = f3; rd_addr_i = rd; alu_result_i = alu; wdata_i = wd;
        bus.mem_rdata_i = rdat;
        bus.mem_ack_i   = stray_ack;
        exp_rw = rw && !(mis && ld); exp_mr = mr; exp_rd = rd; exp_d1 = alu; exp_d2 = '0;
        exp_err = mis; exp_req = 0; exp_we = 0; exp_bus = 0;
        exp_stall = memop && !mis;
        exp_valid = 1;
        stall_cnt = 0; err_cnt = 0; req_cnt = 0; seen_req = 0;
        sample();
        if (memop && !mis) begin
            if (ld) begin be = 4'hF; wdl = '0; end
            else m_lanes(f3, alu, wd, be, wdl);
            timed_out = !(ack_at >= 1 && ack_at <= int'(TO));
            nb = timed_out ? int'(TO) : ack_at;
            exp_addr = alu - (alu % 4);
            exp_be = be;
            exp_wd = wdl;
            for (int i = 1; i <= nb; i++) begin
                next_cycle();
                bus.mem_ack_i = (i == ack_at);
                exp_req = 1; exp_we = !ld; exp_bus = 1; exp_err = 0;
                sample();
            end
            next_cycle();
            bus.mem_ack_i = 0;
            exp_req = 0; exp_we = 0; exp_stall = 0; exp_err = timed_out;
            exp_d2 = (ld && !timed_out) ? m_load(f3, alu, rdat) : '0;
            sample();
        end
        next_cycle();
        bus.mem_ack_i = 0;
    endtask

    task automatic idle_inputs();
        start_i = 0; RegWrite_i = 0; MemReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
        funct3_i = '0; rd_addr_i = '0; alu_result_i = '0; wdata_i = '0;
    endtask

    initial begin
        logic [3:0]  mbe;
        logic [31:0] mwd;
        bus.mem_ack_i = 0;
        bus.mem_rdata_i = '0;
        // Reset held with an aligned LW presented: everything must stay quiet.
        start_i = 1; MemRead_i = 1; RegWrite_i = 1; funct3_i = 3'b010; alu_result_i = 32'h100;
        #12;
        chk("rst_req",   32'(bus.mem_req_o), 32'd0);
        chk("rst_we",    32'(bus.mem_we_o),  32'd0);
        chk("rst_err",   32'(err_o),         32'd0);
        chk("rst_addr",  bus.mem_addr_o,     32'd0);
        chk("rst_wdata", bus.mem_wdata_o,    32'd0);
        chk("rst_be",    32'(bus.mem_be_o),  32'd0);
        chk("rst_stall", 32'(stall_o),       32'd0);
        chk("rst_data2", data2_o,            32'd0);
        idle_inputs();
        next_cycle();
        rst_i = 1;
        next_cycle();

        // Model pins against hand-computed values.
        chk("model_lb",  m_load(3'b000, 32'h103, 32'h80FF1234), 32'hFFFFFF80);
        chk("model_lbu", m_load(3'b100, 32'h103, 32'h80FF1234), 32'h00000080);
        chk("model_lhu", m_load(3'b101, 32'h102, 32'h80FF1234), 32'h000080FF);
        m_lanes(3'b000, 32'h201, 32'h000000AB, mbe, mwd);
        chk("model_sb_wd", mwd, 32'hABABABAB);
        chk("model_sb_be", 32'(mbe), 32'h2);
        m_lanes(3'b001, 32'h202, 32'h00001234, mbe, mwd);
        chk("model_sh_be", 32'(mbe), 32'hC);
        chk("model_lw_mis", 32'(m_misaligned(1, 3'b010, 32'h102)), 32'd1);

        // ADD: no memory op, stray ack ignored.
        run_op(1, 1, 0, 0, 0, 3'b000, 5'd3, 32'h0000_1234, 32'h0, 32'h5555_5555, 0, 1);
        chk("add_stall_cycles", 32'(stall_cnt), 32'd0);
        chk("add_no_req", 32'(req_cnt), 32'd0);

        // LW 0x100, ack on 3rd BUSY cycle.
        run_op(1, 1, 1, 1, 0, 3'b010, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("lw_done_data2",   last_d2, 32'hDEADBEEF);
        chk("lw_done_be",      32'(last_be), 32'hF);
        chk("lw_data1",        last_d1, 32'h100);

        // Load extraction variants.
        run_op(1, 1, 1, 1, 0, 3'b000, 5'd6, 32'h103, 32'h0, 32'h80FF1234, 1, 0);
        chk("lb_data2", last_d2, 32'hFFFFFF80);
        run_op(1, 1, 1, 1, 0, 3'b100, 5'd7, 32'h103, 32'h0, 32'h80FF1234, 2, 0);
        run_op(1, 1, 1, 1, 0, 3'b101, 5'd8, 32'h102, 32'h0, 32'h80FF1234, 1, 0);
        run_op(1, 1, 1, 1, 0, 3'b001, 5'd9, 32'h100, 32'h0, 32'h00008001, 1, 0);
        run_op(1, 1, 1, 1, 0, 3'b000, 5'd10, 32'h101, 32'h0, 32'h0000_7F00, 1, 0);

        // Stores.
        run_op(1, 0, 0, 0, 1, 3'b000, 5'd0, 32'h201, 32'h000000AB, 32'h0, 2, 0);
        chk("sb_addr",  q_addr, 32'h200);
        chk("sb_wdata", q_wd,   32'hABABABAB);
        chk("sb_be",    32'(q_be), 32'h2);
        chk("sb_we",    32'(q_we), 32'd1);
        run_op(1, 0, 0, 0, 1, 3'b001, 5'd0, 32'h202, 32'h00001234, 32'h0, 1, 0);
        chk("sh_be", 32'(q_be), 32'hC);
        run_op(1, 0, 0, 0, 1, 3'b010, 5'd0, 32'h204, 32'hCAFEF00D, 32'h0, 1, 0);

        // Both read and write set: behaves as a load.
        run_op(1, 1, 0, 1, 1, 3'b010, 5'd11, 32'h108, 32'h1111_1111, 32'h0BAD_F00D, 2, 0);

        // Misaligned accesses and illegal sizes.
        run_op(1, 1, 1, 1, 0, 3'b010, 5'd12, 32'h102, 32'h0, 32'h0, 0, 0);
        chk("lw_mis_err",   32'(err_cnt), 32'd1);
        chk("lw_mis_stall", 32'(stall_cnt), 32'd0);
        chk("lw_mis_req",   32'(req_cnt), 32'd0);
        chk("lw_mis_rw",    32'(last_rw), 32'd0);
        run_op(1, 0, 0, 0, 1, 3'b001, 5'd0, 32'h203, 32'h0, 32'h0, 0, 0);
        run_op(1, 1, 1, 1, 0, 3'b011, 5'd13, 32'h100, 32'h0, 32'h0, 0, 0);
        run_op(1, 0, 0, 0, 1, 3'b100, 5'd0, 32'h100, 32'h0, 32'h0, 0, 0);

        // Pipeline not running: no access even for a misaligned address.
        run_op(0, 1, 1, 1, 0, 3'b010, 5'd14, 32'h102, 32'h0, 32'h0, 0, 0);
        run_op(0, 1, 1, 1, 0, 3'b010, 5'd14, 32'h100, 32'h0, 32'h0, 0, 0);

        // Timeout, then ack exactly on the expiry cycle.
        run_op(1, 1, 1, 1, 0, 3'b010, 5'd15, 32'h300, 32'h0, 32'h12345678, 0, 0);
        chk("to_err",   32'(err_cnt), 32'd1);
        chk("to_data2", last_d2, 32'd0);
        chk("to_stall", 32'(stall_cnt), 32'(1 + TO));
        run_op(1, 1, 1, 1, 0, 3'b010, 5'd15, 32'h300, 32'h0, 32'h12345678, int'(TO), 0);
        chk("to_ack_err",   32'(err_cnt), 32'd0);
        chk("to_ack_data2", last_d2, 32'h12345678);

        // Reset in the middle of BUSY.
        exp_valid = 0;
        start_i = 1; MemRead_i = 1; RegWrite_i = 1; funct3_i = 3'b010; alu_result_i = 32'h400;
        next_cycle();
        next_cycle();
        chk("pre_rst_req", 32'(bus.mem_req_o), 32'd1);
        rst_i = 0;
        #1;
        chk("midrst_req",   32'(bus.mem_req_o), 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_addr",  bus.mem_addr_o, 32'd0);
        idle_inputs();
        next_cycle();
        rst_i = 1;
        next_cycle();
        run_op(1, 1, 0, 0, 0, 3'b000, 5'd1, 32'h0000_0042, 32'h0, 32'h0, 0, 0);
        chk("post_rst_req", 32'(req_cnt), 32'd0);
        run_op(1, 1, 0, 0, 0, 3'b000, 5'd2, 32'h0000_0043, 32'h0, 32'h0, 0, 0);
        run_op(1, 1, 1, 1, 0, 3'b010, 5'd4, 32'h400, 32'h0, 32'hA5A5_5A5A, 1, 0);
        chk("post_rst_lw", last_d2, 32'hA5A55A5A);

        exp_valid = 0;
        idle_inputs();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the address and store data from EX/MEM and runs one load or store per instruction over a req/ack data-memory port. It also sign- or zero-extends load data and presents ALU result, load data and writeback control to MEM/WB. While an access is outstanding it freezes the pipeline through `stall_o`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles without `mem_ack_i` before the access is abandoned.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: pipeline running. When 0, no new access is launched; an access already in flight completes.
- `RegWrite_i`, `MemReg_i`, `MemRead_i`, `MemWrite_i` in 1 each: control from EX/MEM.
- `funct3_i` in 3: access size/sign.
- `rd_addr_i` in 5: destination register.
- `alu_result_i` in 32: byte address / ALU result.
- `wdata_i` in 32: store data (rs2).
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: request is a write.
- `mem_addr_o` out 32: word-aligned address.
- `mem_wdata_o` out 32: lane-replicated store data.
- `mem_be_o` out 4: byte enables.
- `mem_ack_i` in 1: request done; read data valid this cycle.
- `mem_rdata_i` in 32: read word.
- `RegWrite_o`, `MemReg_o` out 1 each: to MEM/WB.
- `rd_addr_o` out 5: to MEM/WB.
- `data1_o` out 32: ALU result.
- `data2_o` out 32: extended load data.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX, EX/MEM and hold MEM/WB.
- `err_o` out 1: one-cycle pulse on misaligned access or timeout.

## Operation
- Memory op means `start_i & (MemRead_i | MemWrite_i)`. `MemRead_i` has priority if both are set.
- Sizes (little-endian):
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other `funct3_i` on a memory op is treated as misaligned.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. No request is issued and there is no stall. `err_o` pulses and `data2_o`=0. For a load, `RegWrite_o` is forced 0.
- `mem_addr_o` = {addr[31:2],2'b00}.
- Store lanes:
  - SB: data replicated ×4, `mem_be_o` = 1<<addr[1:0].
  - SH: replicated ×2, `mem_be_o` = addr[1] ? 1100 : 0011.
  - SW: `mem_be_o` = 1111.
  - Loads use `mem_be_o` = 1111.
- Load extraction: select the byte/half by addr[1:0], then sign- or zero-extend to 32 bits.
- FSM:
  - IDLE → BUSY on an aligned memory op. Request fields are registered on this edge.
  - BUSY → DONE on `mem_ack_i`. Read data is extracted and captured into the load-data register.
  - BUSY → DONE on timeout. `err_o` pulses and the captured data is 0.
  - DONE → IDLE unconditionally.
- `mem_req_o`/`mem_we_o` are high in BUSY only.
- `mem_ack_i` outside BUSY is ignored.
- Output muxing:
  - `RegWrite_o`, `MemReg_o`, `rd_addr_o` and `data1_o` pass combinationally from inputs, except the misaligned-load override.
  - `data2_o` is the captured register in DONE, else 0.
- `stall_o` = (IDLE & aligned memory op) | BUSY. It is 0 in DONE and for non-memory instructions.

## Timing
- Reset (`rst_i`=0) forces, asynchronously:
  - state IDLE;
  - `mem_req_o`, `mem_we_o`, `err_o` = 0;
  - `mem_addr_o`, `mem_wdata_o`, `mem_be_o` = 0;
  - captured data and timeout counter = 0;
  - `stall_o` = 0.
- Reset mid-BUSY drops `mem_req_o` immediately; the access is abandoned.
- Non-memory instruction: 0 stall cycles.
- Memory op with ack on the k-th BUSY cycle (k≥1): `stall_o` high for 1+k cycles; DONE is cycle k+2. MEM/WB captures at the end of DONE.
- Timeout: the counter increments each BUSY cycle without ack. At `TIMEOUT_CYCLES` it forces DONE. An ack arriving in the same cycle as expiry wins: no error, data is captured.
- `err_o`: combinational pulse in the IDLE cycle for misalignment; registered pulse in the DONE cycle for timeout.

## Test plan
- Reset mid-access: assert `rst_i`=0 during BUSY → `mem_req_o`=0 the same cycle. After release, state is IDLE with no spurious request or stall.
- LW, addr 0x100, ack after 3 BUSY cycles, `mem_rdata_i`=0xDEADBEEF:
  - `stall_o` high for 4 cycles;
  - DONE shows `data2_o`=0xDEADBEEF and `mem_be_o`=1111;
  - `data1_o`=0x100.
- LB at 0x103 with rdata 0x80FF1234 → `data2_o`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB at 0x201, `wdata_i`=0x000000AB → `mem_addr_o`=0x200, `mem_wdata_o`=0xABABABAB, `mem_be_o`=0010, `mem_we_o`=1. SH at 0x202 → `mem_be_o`=1100.
- LW at 0x102 → no `mem_req_o`, `stall_o`=0, `err_o` pulse, `RegWrite_o`=0. ADD instruction (no memory op) → zero stall, `data1_o` passes through.
- `TIMEOUT_CYCLES`=4 with no ack → DONE after 4 BUSY cycles, `err_o`=1, `data2_o`=0. Repeat with ack on the 4th cycle → no error, data captured.
